// File: rtl/half_band_interp_1.sv
// Half-band interpolate-by-2: even phase is a pure delay, odd phase a 4-tap symmetric FIR on one shared
// multiplier over 4 clocks; outputs 2 clocks apart, no backpressure. Macro HB_INTERP_SAT_EN saturates the odd output.
module half_band_interp_1 #(
  parameter logic signed [17:0] COEF_B    = -18'sd12940,
  parameter logic signed [17:0] COEF_B1   = 18'sd77324,
  parameter int unsigned        OUT_SHIFT = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic signed [17:0] x_in,
  output logic signed [17:0] y,
  output logic               y_valid
);

  logic signed [17:0] d0, d1, d2, d3;
  logic signed [36:0] mult_out;
  logic signed [37:0] acc;
  logic [1:0]         k;
  logic               busy;

  logic signed [18:0] pre_sum;
  logic signed [17:0] coef;
  logic signed [36:0] op_a, op_b, product;
  logic signed [17:0] odd_val;

  // Shared multiplier: outer pair at k=0, inner pair otherwise
  always_comb begin
    pre_sum = {d1[17], d1} + {d2[17], d2};
    coef    = COEF_B1;
    if (k == 2'd0) begin
      pre_sum = {d0[17], d0} + {d3[17], d3};
      coef    = COEF_B;
    end
    op_a    = {{19{coef[17]}}, coef};
    op_b    = {{18{pre_sum[18]}}, pre_sum};
    product = op_a * op_b;
  end

`ifdef HB_INTERP_SAT_EN
  localparam logic signed [37:0] SAT_MAX = 38'sd131071;
  localparam logic signed [37:0] SAT_MIN = -38'sd131072;
  logic signed [37:0] acc_shr;

  always_comb begin
    acc_shr = acc >>> OUT_SHIFT;
    odd_val = acc_shr[17:0];
    if (acc_shr > SAT_MAX) begin
      odd_val = 18'sh1FFFF;
    end else if (acc_shr < SAT_MIN) begin
      odd_val = 18'sh20000;
    end
  end
`else
  // Low 18 bits of the arithmetic shift are just this slice of acc; wraps on overflow.
  always_comb begin
    odd_val = acc[OUT_SHIFT +: 18];
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      mult_out <= '0;
      acc      <= '0;
      y        <= '0;
      y_valid  <= 1'b0;
      k        <= 2'd3;
      busy     <= 1'b0;
    end else begin
      y_valid <= 1'b0;
      if (busy && (k == 2'd3)) begin
        y       <= odd_val;
        y_valid <= 1'b1;
        busy    <= 1'b0;
      end else if (busy && !clk_en) begin
        // An early strobe suppresses the step of the cycle it lands in
        unique case (k)
          2'd0: mult_out <= product;
          2'd1: begin
            mult_out <= product;
            acc      <= {mult_out[36], mult_out};
            y        <= d2;
            y_valid  <= 1'b1;
          end
          2'd2: acc <= acc + {mult_out[36], mult_out};
          default: ;
        endcase
        k <= k + 2'd1;
      end
      if (clk_en) begin
        d0   <= x_in >>> 1;
        d1   <= d0;
        d2   <= d1;
        d3   <= d2;
        k    <= 2'd0;
        busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_band_interp_1.sv
// Bench for half_band_interp_1: table vectors, corner sequences and randomized strobes
// checked against a sample-history reference model.
module tb_half_band_interp_1;

  logic               clk     = 1'b0;
  logic               reset   = 1'b0;
  logic               clk_en  = 1'b0;
  logic               clk_en2 = 1'b0;
  logic signed [17:0] x_in    = '0;
  logic signed [17:0] x_in2   = '0;
  logic signed [17:0] y, y2;
  logic               y_valid, y_valid2;

  always #5 clk = ~clk;

  half_band_interp_1 dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in), .y(y), .y_valid(y_valid)
  );

  half_band_interp_1 #(.COEF_B(18'sd131071), .COEF_B1(18'sd131071)) dut_ovf (
    .clk(clk), .reset(reset), .clk_en(clk_en2), .x_in(x_in2), .y(y2), .y_valid(y_valid2)
  );

  typedef struct {
    int x;
    int even;
    int odd;
    bit chk;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;
  bit   cap_v[int];
  int   cap_d[int];
  bit   exp_v[int];
  int   exp_d[int];
  int   h0, h1, h2, h3;
  bit   have_prev;
  int   last_p;
  int   vfy_next = 1;
  int   model_y;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(negedge clk) begin
    cap_v[edge_cnt] = y_valid;
    cap_d[edge_cnt] = int'(y);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int odd_model(input int a0, input int a1, input int a2, input int a3,
                                   input int b, input int b1);
    longint acc;
    longint sh;
    int     w;
    acc = longint'(b) * longint'(a0 + a3) + longint'(b1) * longint'(a1 + a2);
    sh  = acc >>> 17;
`ifdef HB_INTERP_SAT_EN
    if (sh > 64'sd131071) return 131071;
    if (sh < -64'sd131072) return -131072;
    w = int'(sh);
`else
    w = int'(sh & 64'h3FFFF);
    if (w >= 131072) w = w - 262144;
`endif
    return w;
  endfunction

  task automatic model_clear();
    exp_v.delete();
    exp_d.delete();
    h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    have_prev = 1'b0;
    model_y = 0;
  endtask

  // A period's even output needs 3 clean cycles, its odd output 4, before the next strobe.
  task automatic model_strobe(input int x, input int p);
    if (have_prev) begin
      if (p - last_p < 4) exp_v[last_p + 4] = 1'b0;
      if (p - last_p < 3) exp_v[last_p + 2] = 1'b0;
    end
    h3 = h2; h2 = h1; h1 = h0; h0 = x >>> 1;
    exp_v[p + 2] = 1'b1;
    exp_d[p + 2] = h2;
    exp_v[p + 4] = 1'b1;
    exp_d[p + 4] = odd_model(h0, h1, h2, h3, -12940, 77324);
    last_p    = p;
    have_prev = 1'b1;
  endtask

  task automatic strobe(input int x);
    clk_en = 1'b1;
    x_in   = x[17:0];
    model_strobe(x, edge_cnt + 1);
    @(negedge clk);
    clk_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic verify_to_now();
    #1;
    for (int e = vfy_next; e <= edge_cnt; e++) begin
      bit v;
      v = exp_v.exists(e) ? exp_v[e] : 1'b0;
      if (v) model_y = exp_d[e];
      check($sformatf("vld@%0d", e), int'(cap_v[e]), int'(v));
      check($sformatf("y@%0d", e), cap_d[e], model_y);
    end
    vfy_next = edge_cnt + 1;
  endtask

  task automatic do_reset();
    verify_to_now();
    reset   = 1'b0;
    clk_en  = 1'b0;
    clk_en2 = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    check("rst_y", int'(y), 0);
    check("rst_vld", int'(y_valid), 0);
    check("rst_y2", int'(y2), 0);
    reset    = 1'b1;
    vfy_next = edge_cnt + 1;
  endtask

  task automatic run_table(input int lo, input int hi);
    int pp[$];
    for (int i = lo; i <= hi; i++) begin
      pp.push_back(edge_cnt + 1);
      strobe(tbl[i].x);
      idle(3);
    end
    idle(6);
    verify_to_now();
    for (int i = lo; i <= hi; i++) begin
      if (tbl[i].chk) begin
        check($sformatf("tbl%0d_even_vld", i), int'(cap_v[pp[i-lo] + 2]), 1);
        check($sformatf("tbl%0d_even", i), cap_d[pp[i-lo] + 2], tbl[i].even);
        check($sformatf("tbl%0d_odd_vld", i), int'(cap_v[pp[i-lo] + 4]), 1);
        check($sformatf("tbl%0d_odd", i), cap_d[pp[i-lo] + 4], tbl[i].odd);
      end
    end
  endtask

  task automatic mid_reset(input int k_at);
    strobe(100000);
    idle(k_at);
    verify_to_now();
    reset = 1'b0;
    #1;
    check($sformatf("async_y_k%0d", k_at), int'(y), 0);
    check($sformatf("async_vld_k%0d", k_at), int'(y_valid), 0);
    model_clear();
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    vfy_next = edge_cnt + 1;
    idle(12);
    verify_to_now();
  endtask

  task automatic add(input int x, input int e, input int o, input bit c);
    vec_t v;
    v.x = x; v.even = e; v.odd = o; v.chk = c;
    tbl.push_back(v);
  endtask

  initial begin
    int pa, pb, po;

    // DC: rows 0-5
    for (int i = 0; i < 6; i++) add(100000, 50000, 49121, i >= 3);
    // Impulse: rows 6-10
    add(131070, 0, -6470, 1'b1);
    add(0, 0, 38661, 1'b1);
    add(0, 65535, 38661, 1'b1);
    add(0, 0, -6470, 1'b1);
    add(0, 0, 0, 1'b1);
    // Full-scale negative DC: rows 11-15
    for (int i = 0; i < 5; i++) add(-131072, -65536, -64384, i >= 3);

    do_reset();
    idle(10);
    verify_to_now();

    run_table(0, 5);
    mid_reset(1);
    mid_reset(2);
    run_table(6, 10);
    run_table(11, 15);

    // Strobe landing at k=2: first period keeps its even output only
    do_reset();
    pa = edge_cnt + 1;
    strobe(40000);
    idle(2);
    pb = edge_cnt + 1;
    strobe(-30000);
    idle(8);
    verify_to_now();
    check("early_k2_even_vld", int'(cap_v[pa + 2]), 1);
    check("early_k2_odd_vld", int'(cap_v[pa + 4]), 0);
    check("early_k2_next_even_vld", int'(cap_v[pb + 2]), 1);
    check("early_k2_next_odd_vld", int'(cap_v[pb + 4]), 1);
    check("early_k2_next_odd", cap_d[pb + 4], 13279);

    // Strobe landing at k=1: first period emits nothing
    pa = edge_cnt + 1;
    strobe(40000);
    idle(1);
    pb = edge_cnt + 1;
    strobe(-30000);
    idle(8);
    verify_to_now();
    check("early_k1_even_vld", int'(cap_v[pa + 2]), 0);
    check("early_k1_next_even_vld", int'(cap_v[pb + 2]), 1);

    // Accumulator overflow with full-scale coefficients
    do_reset();
    po = 0;
    for (int i = 0; i < 4; i++) begin
      clk_en2 = 1'b1;
      x_in2   = 18'sd131071;
      po      = edge_cnt + 1;
      @(negedge clk);
      clk_en2 = 1'b0;
      idle(3);
    end
    idle(1);
    #1;
    check("ovf_vld", int'(y_valid2), 1);
    check("ovf_y_model", int'(y2), odd_model(65535, 65535, 65535, 65535, 131071, 131071));
`ifdef HB_INTERP_SAT_EN
    check("ovf_y", int'(y2), 131071);
`else
    check("ovf_y", int'(y2), -6);
`endif

    // Randomized samples and strobe spacing
    do_reset();
    for (int n = 0; n < 300; n++) begin
      int r;
      int gap;
      r = int'($urandom_range(0, 9));
      if (r < 6)       gap = 4;
      else if (r == 6) gap = 1;
      else if (r == 7) gap = 2;
      else if (r == 8) gap = 3;
      else             gap = int'($urandom_range(5, 9));
      strobe(int'($urandom_range(0, 262143)) - 131072);
      if (gap > 1) idle(gap - 1);
    end
    idle(8);
    verify_to_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
